// File: rtl/image_buf_pkg.sv
// Shared types, sizing helpers and bank mapping for the stereo ping-pong frame buffer.
package image_buf_pkg;

    localparam int DEF_HSIZE      = 100;
    localparam int DEF_VSIZE      = 100;
    localparam int DEF_PIXEL_SIZE = 12;

    typedef logic [DEF_PIXEL_SIZE-1:0] pixel_t;

    // Number of bits needed to hold the value itself, so an address equal to
    // the frame size is representable and can be flagged as out of range.
    function automatic int log2(input int value);
        int bits;
        bits = 1;
        for (int b = 1; b < 31; b++) begin
            if ((value >> b) != 0) bits = b + 1;
        end
        return bits;
    endfunction

    function automatic int frame_pixels(input int hsize, input int vsize);
        return hsize * vsize;
    endfunction

    // The reader always owns the bank the writers are not filling.
    function automatic logic read_bank(input logic write_bank);
        return ~write_bank;
    endfunction

endpackage

// File: rtl/buf_bank_ram.sv
// Simple dual-port synchronous RAM holding both banks of one channel.
module buf_bank_ram #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 12
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read register holds between reads; array contents are never reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)   rdata_q <= '0;
        else if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/stereo_pingpong_buffer.sv
// Multi-channel ping-pong frame buffer: raster writes per channel, shared-address random reads.
// Define IMAGE_BUF_OUTREG_EN to add an output register stage (read latency 2 instead of 1).
module stereo_pingpong_buffer
    import image_buf_pkg::*;
#(
    parameter int CAMERA_HSIZE   = DEF_HSIZE,
    parameter int CAMERA_VSIZE   = DEF_VSIZE,
    parameter int BUF_ADDR_WIDTH = log2(CAMERA_HSIZE * CAMERA_VSIZE),
    parameter int PIXEL_SIZE     = DEF_PIXEL_SIZE,
    parameter int NUM_CH         = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_CH-1:0]            buf_wvalid,
    output logic [NUM_CH-1:0]            buf_wready,
    input  logic [NUM_CH*PIXEL_SIZE-1:0] buf_wdata,
    input  logic [BUF_ADDR_WIDTH-1:0]    buf_raddr,
    input  logic                         buf_rvalid,
    output logic                         buf_rready,
    output logic [NUM_CH*PIXEL_SIZE-1:0] buf_rdata,
    output logic                         buf_rdata_valid,
    output logic                         buf_rerr,
    input  logic                         buf_rdone,
    output logic                         frame_ready
);

    localparam int                      AW    = BUF_ADDR_WIDTH;
    localparam int                      DW    = NUM_CH * PIXEL_SIZE;
    localparam int                      FRAME = frame_pixels(CAMERA_HSIZE, CAMERA_VSIZE);
    localparam logic [AW-1:0]           LAST  = AW'(FRAME - 1);
    localparam logic [AW:0]             LIMIT = (AW + 1)'(FRAME);

    logic              wb_q, wb_d;
    logic              frame_ready_q, frame_ready_d;
    logic [NUM_CH-1:0] fill_done_q, fill_done_d;
    logic [NUM_CH-1:0] wr_en, done_now;
    logic [AW-1:0]     wcnt_q [NUM_CH];
    logic [AW-1:0]     wcnt_d [NUM_CH];
    logic              swap, rd_accept, rd_oor;
    logic              rd_valid1_q, rd_err1_q;
    logic [DW-1:0]     ram_rdata, rdata1;

    // A channel's final write counts toward the swap in the same cycle it lands.
    always_comb begin
        wr_en         = buf_wvalid & ~fill_done_q;
        done_now      = fill_done_q;
        fill_done_d   = fill_done_q;
        wb_d          = wb_q;
        frame_ready_d = frame_ready_q;
        for (int c = 0; c < NUM_CH; c++) begin
            wcnt_d[c] = wcnt_q[c];
            if (wr_en[c]) begin
                if (wcnt_q[c] == LAST) done_now[c] = 1'b1;
                else                   wcnt_d[c]   = wcnt_q[c] + 1'b1;
            end
        end
        fill_done_d = done_now;
        swap        = (&done_now) && (!frame_ready_q || buf_rdone);
        if (swap) begin
            wb_d          = ~wb_q;
            frame_ready_d = 1'b1;
            fill_done_d   = '0;
            for (int c = 0; c < NUM_CH; c++) wcnt_d[c] = '0;
        end else if (buf_rdone) begin
            frame_ready_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_q          <= 1'b0;
            frame_ready_q <= 1'b0;
            fill_done_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) wcnt_q[c] <= '0;
        end else begin
            wb_q          <= wb_d;
            frame_ready_q <= frame_ready_d;
            fill_done_q   <= fill_done_d;
            for (int c = 0; c < NUM_CH; c++) wcnt_q[c] <= wcnt_d[c];
        end
    end

    assign buf_wready  = ~fill_done_q;
    assign buf_rready  = frame_ready_q;
    assign frame_ready = frame_ready_q;
    assign rd_accept   = buf_rvalid && frame_ready_q;
    assign rd_oor      = {1'b0, buf_raddr} >= LIMIT;

    // Bank is the RAM address MSB; the read uses the bank as seen in the accept cycle.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        buf_bank_ram #(
            .ADDR_W (AW + 1),
            .DATA_W (PIXEL_SIZE)
        ) u_ram (
            .clk_i   (clk),
            .rst_ni  (rst_n),
            .we_i    (wr_en[c]),
            .waddr_i ({wb_q, wcnt_q[c]}),
            .wdata_i (buf_wdata[c*PIXEL_SIZE +: PIXEL_SIZE]),
            .re_i    (rd_accept),
            .raddr_i ({read_bank(wb_q), buf_raddr}),
            .rdata_o (ram_rdata[c*PIXEL_SIZE +: PIXEL_SIZE])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid1_q <= 1'b0;
            rd_err1_q   <= 1'b0;
        end else begin
            rd_valid1_q <= rd_accept;
            if (rd_accept) rd_err1_q <= rd_oor;
        end
    end

    assign rdata1 = rd_err1_q ? '0 : ram_rdata;

`ifdef IMAGE_BUF_OUTREG_EN
    logic [DW-1:0] rdata2_q;
    logic          rd_valid2_q, rd_err2_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata2_q    <= '0;
            rd_valid2_q <= 1'b0;
            rd_err2_q   <= 1'b0;
        end else begin
            rd_valid2_q <= rd_valid1_q;
            if (rd_valid1_q) begin
                rdata2_q  <= rdata1;
                rd_err2_q <= rd_err1_q;
            end
        end
    end

    assign buf_rdata       = rdata2_q;
    assign buf_rdata_valid = rd_valid2_q;
    assign buf_rerr        = rd_err2_q;
`else
    assign buf_rdata       = rdata1;
    assign buf_rdata_valid = rd_valid1_q;
    assign buf_rerr        = rd_err1_q;
`endif

endmodule

// File: tb/tb_stereo_pingpong_buffer.sv
// Randomized scoreboard bench for stereo_pingpong_buffer (4x4 frames, two channels).
module tb_stereo_pingpong_buffer;

    localparam int H     = 4;
    localparam int V     = 4;
    localparam int NCH   = 2;
    localparam int PIX   = 12;
    localparam int AW    = 5;
    localparam int FRAME = H * V;
    localparam int DW    = NCH * PIX;
`ifdef IMAGE_BUF_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    buf_wvalid;
    logic [NCH-1:0]    buf_wready;
    logic [DW-1:0]     buf_wdata;
    logic [AW-1:0]     buf_raddr;
    logic              buf_rvalid;
    logic              buf_rready;
    logic [DW-1:0]     buf_rdata;
    logic              buf_rdata_valid;
    logic              buf_rerr;
    logic              buf_rdone;
    logic              frame_ready;

    stereo_pingpong_buffer #(
        .CAMERA_HSIZE (H),
        .CAMERA_VSIZE (V),
        .PIXEL_SIZE   (PIX),
        .NUM_CH       (NCH)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .buf_wvalid      (buf_wvalid),
        .buf_wready      (buf_wready),
        .buf_wdata       (buf_wdata),
        .buf_raddr       (buf_raddr),
        .buf_rvalid      (buf_rvalid),
        .buf_rready      (buf_rready),
        .buf_rdata       (buf_rdata),
        .buf_rdata_valid (buf_rdata_valid),
        .buf_rerr        (buf_rerr),
        .buf_rdone       (buf_rdone),
        .frame_ready     (frame_ready)
    );

    // ---------------- clock / cycle count ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [DW:0] exp_q[$];
    int          due_q[$];

    // Behavioural model: frames as plain arrays, one being filled and one readable.
    logic [PIX-1:0] wr_frame [NCH][FRAME];
    logic [PIX-1:0] rd_frame [NCH][FRAME];
    int             wn [NCH];
    bit             fr_m;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) wn[c] = 0;
        fr_m = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_wready", 32'(buf_wready), 32'(2'b11));
        check("rst_rready", 32'(buf_rready), 0);
        check("rst_frame_ready", 32'(frame_ready), 0);
        check("rst_rdata", 32'(buf_rdata), 0);
        check("rst_rdata_valid", 32'(buf_rdata_valid), 0);
        check("rst_rerr", 32'(buf_rerr), 0);
    endtask

    // ---------------- monitor ----------------
    logic [DW:0] mon_e;
    int          mon_due;
    always @(negedge clk) begin
        if (rst_n) begin
            if (due_q.size() != 0 && due_q[0] < cyc && !buf_rdata_valid) begin
                check("rd_missing", 0, 1);
                void'(exp_q.pop_front());
                void'(due_q.pop_front());
            end
            if (buf_rdata_valid) begin
                if (exp_q.size() == 0) begin
                    check("rd_unexpected", 1, 0);
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_due = due_q.pop_front();
                    check("rdata", 32'(buf_rdata), 32'(mon_e[DW-1:0]));
                    check("rerr", 32'(buf_rerr), 32'(mon_e[DW]));
                    check("rd_latency", cyc, mon_due);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // One cycle: compare control outputs with the model, drive new inputs,
    // then advance the model to the state after the coming clock edge.
    task automatic step(input int pw0, input int pw1, input int pr, input int pd,
                        input int poor, input bit pat, input int fa);
        logic [NCH-1:0] ew;
        logic [NCH-1:0] wv;
        logic [PIX-1:0] wd [NCH];
        logic           rv, rd;
        logic [AW-1:0]  ra;
        bit             all_full;
        logic [DW-1:0]  rexp;
        @(negedge clk);
        for (int c = 0; c < NCH; c++) ew[c] = (wn[c] < FRAME);
        check("wready", 32'(buf_wready), 32'(ew));
        check("frame_ready", 32'(frame_ready), 32'(fr_m));
        check("rready", 32'(buf_rready), 32'(fr_m));

        wv[0] = ($urandom_range(0, 99) < pw0);
        wv[1] = ($urandom_range(0, 99) < pw1);
        for (int c = 0; c < NCH; c++) begin
            if (pat) wd[c] = PIX'(c * 'h100 + wn[c]);
            else     wd[c] = PIX'($urandom);
        end
        rv = ($urandom_range(0, 99) < pr);
        rd = ($urandom_range(0, 99) < pd);
        if (fa >= 0)                             ra = AW'(fa);
        else if ($urandom_range(0, 99) < poor)   ra = AW'($urandom_range(FRAME, 31));
        else                                     ra = AW'($urandom_range(0, FRAME - 1));

        buf_wvalid = wv;
        buf_wdata  = {wd[1], wd[0]};
        buf_rvalid = rv;
        buf_raddr  = ra;
        buf_rdone  = rd;

        for (int c = 0; c < NCH; c++) begin
            if (wv[c] && wn[c] < FRAME) begin
                wr_frame[c][wn[c]] = wd[c];
                wn[c]++;
            end
        end
        if (rv && fr_m) begin
            if (int'(ra) >= FRAME) begin
                exp_q.push_back({1'b1, {DW{1'b0}}});
            end else begin
                rexp = {rd_frame[1][ra], rd_frame[0][ra]};
                exp_q.push_back({1'b0, rexp});
            end
            due_q.push_back(cyc + LAT);
        end
        all_full = 1'b1;
        for (int c = 0; c < NCH; c++) if (wn[c] != FRAME) all_full = 1'b0;
        if (all_full && (!fr_m || rd)) begin
            rd_frame = wr_frame;
            for (int c = 0; c < NCH; c++) wn[c] = 0;
            fr_m = 1'b1;
        end else if (rd) begin
            fr_m = 1'b0;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n      = 1'b0;
        buf_wvalid = '0;
        buf_wdata  = '0;
        buf_rvalid = 1'b0;
        buf_raddr  = '0;
        buf_rdone  = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst_n = 1'b1;

        // First frame with a recognisable pattern, then a read of pixel 5.
        for (int i = 0; i < 40 && !fr_m; i++) step(100, 100, 0, 0, 0, 1'b1, -1);
        step(0, 0, 100, 0, 0, 1'b0, 5);
        step(0, 0, 100, 0, 0, 1'b0, FRAME);
        step(0, 0, 100, 0, 0, 1'b0, FRAME - 1);

        // Back-pressure: next frame fills and stalls without a release.
        repeat (30) step(100, 100, 60, 0, 10, 1'b0, -1);
        step(0, 0, 100, 100, 0, 1'b0, 3);
        repeat (10) step(0, 0, 80, 0, 0, 1'b0, -1);

        // Uneven channels and random releases.
        repeat (150) step(90, 40, 70, 8, 10, 1'b0, -1);
        repeat (300) step($urandom_range(20, 100), $urandom_range(20, 100),
                          $urandom_range(0, 100), $urandom_range(0, 30), 15, 1'b0, -1);

        // Mid-frame reset with a complete frame already readable.
        for (int i = 0; i < 100; i++) begin
            step(100, 100, 0, 100, 0, 1'b0, -1);
            if (fr_m && wn[0] == 0 && wn[1] == 0) break;
        end
        repeat (7) step(100, 100, 0, 0, 0, 1'b0, -1);
        @(negedge clk);
        buf_wvalid = '0;
        buf_rvalid = 1'b0;
        buf_rdone  = 1'b0;
        rst_n      = 1'b0;
        #1;
        check_reset_outputs();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Refill from scratch and keep going.
        repeat (250) step($urandom_range(30, 100), $urandom_range(30, 100),
                          $urandom_range(20, 100), $urandom_range(0, 25), 10, 1'b0, -1);

        repeat (LAT + 3) step(0, 0, 0, 0, 0, 1'b0, -1);
        check("exp_q_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/stereo_pingpong_buffer.md
Name: stereo_pingpong_buffer

Overview:
- Multi-channel, double-banked (ping-pong) frame buffer for the SAD disparity pipeline.
- Each channel (default 2: left/right camera) streams raster pixels into the write bank while the SAD engine randomly reads the previously completed frame from the read bank.
- All channels are read at one shared address per request, so the matching left/right pixels arrive together.
- Banks swap only when every channel has finished a frame and the reader has released the read bank.

Parameters:
CAMERA_HSIZE, 100, pixels per line
CAMERA_VSIZE, 100, lines per frame
BUF_ADDR_WIDTH, log2(CAMERA_HSIZE*CAMERA_VSIZE), pixel address width
PIXEL_SIZE, 12, bits per pixel
NUM_CH, 2, number of camera channels (1..4)

Ports:
clk  in  1  clock
rst_n  in  1  reset
buf_wvalid  in  NUM_CH  per-channel write pixel valid
buf_wready  out  NUM_CH  per-channel write accept
buf_wdata  in  NUM_CH*PIXEL_SIZE  per-channel raster pixel; channel c occupies bits [c*PIXEL_SIZE +: PIXEL_SIZE]
buf_raddr  in  BUF_ADDR_WIDTH  read pixel address (row*HSIZE+col)
buf_rvalid  in  1  read request
buf_rready  out  1  read accept
buf_rdata  out  NUM_CH*PIXEL_SIZE  read data, all channels
buf_rdata_valid  out  1  buf_rdata qualifier
buf_rerr  out  1  out-of-range read flag, qualified by buf_rdata_valid
buf_rdone  in  1  reader releases the read bank (single-cycle pulse)
frame_ready  out  1  read bank holds a complete frame

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low. Reset clears all flops; RAM contents are not reset.
- Reset values: buf_wready = all 1, buf_rready = 0, buf_rdata = 0, buf_rdata_valid = 0, buf_rerr = 0, frame_ready = 0, write bank wb = 0.
- Write path:
  - Each channel has a counter wcnt[c]; a write occurs on buf_wvalid[c] && buf_wready[c] at address {wb, wcnt[c]}.
  - At wcnt[c] == HSIZE*VSIZE-1, the write sets fill_done[c] and holds the counter.
  - buf_wready[c] = !fill_done[c]. A channel that finishes early stalls until the swap.
- Swap condition: &fill_done && (!frame_ready || buf_rdone).
  - On swap: wb toggles, frame_ready = 1, all wcnt and fill_done clear.
  - The write bank reopens in the next cycle, so wready returns high one cycle after the swap.
- Release: buf_rdone with frame_ready and no simultaneous swap clears frame_ready. buf_rdone while frame_ready = 0 is ignored.
- Read path:
  - buf_rready = frame_ready. A read is accepted on buf_rvalid && buf_rready, using read bank !wb as sampled in the accept cycle.
  - Read latency is 1 cycle: buf_rdata_valid pulses the cycle after accept. One read per cycle, fully pipelined.
  - buf_rdata holds its value between reads.
  - If buf_raddr >= HSIZE*VSIZE: buf_rdata = 0 and buf_rerr = 1 with buf_rdata_valid.
- Simultaneous events:
  - Read accept and buf_rdone in the same cycle: the read is served from the old bank, then the bank is released.
  - Swap and read accept in the same cycle: the read uses the pre-swap bank.
- Reset mid-frame: partial frames are discarded, frame_ready = 0, and any in-flight read is dropped (no rdata_valid).
- Address arithmetic: unsigned, BUF_ADDR_WIDTH bits. Internal RAM address is BUF_ADDR_WIDTH+1 bits, with the MSB selecting the bank.

Optional Feature:
IMAGE_BUF_OUTREG_EN
- Defined: adds an output register stage; read latency is 2 cycles. buf_rdata_valid and buf_rerr are delayed to match. Throughput is unchanged.
- Undefined: read latency is 1 cycle, as above.

Decomposition:
- Package image_buf_pkg holds:
  - log2 function
  - pixel_t typedef (logic [PIXEL_SIZE-1:0])
  - FRAME_PIXELS constant expression
  - Bank-select helper
- One sub-module, buf_bank_ram: simple dual-port synchronous RAM, depth 2*HSIZE*VSIZE, width PIXEL_SIZE, one write port and one read port. Instantiate one per channel in a generate loop.

Test Plan:
- Basic fill and read: H=V=4, NUM_CH=2. Write ch0 = 0..15 and ch1 = 0x100+i. The cycle after the last accept, frame_ready=1 and wb=1. Read addr 5 -> one cycle later rdata = {0x105, 0x005}, rdata_valid=1.
- Back-pressure: fill frame 2 while frame_ready=1 without rdone. After 16 writes per channel, wready=0 and holds. Pulse rdone -> swap in that cycle, wready=1 the next cycle; reading addr 5 returns frame-2 data.
- Uneven channels: ch0 finishes 3 cycles before ch1 -> wready[0]=0 for those cycles, no swap until ch1's last write, frame_ready=1 the cycle after.
- Out-of-range read: raddr 16 -> rdata=0, rerr=1, rdata_valid=1. The following read of raddr 15 returns valid data with rerr=0.
- Simultaneous rdone and read on addr 3 in the swap cycle -> returned data is from the old frame. Subsequent reads return the new frame.
- Reset mid-frame: assert rst_n=0 after 7 writes -> frame_ready=0 and wready all 1 immediately. A refill from 0 completes normally.
